bounce_generator: RTL and testbench

- Synthesizable mechanical-button emulator: the driving end of the Debounce input path.
- On a level request it drives button_out through a burst of pseudo-random glitches, then settles cleanly on the requested level and holds it.
- Used for hardware-in-loop self-test of Debounce on the 100 MHz board clock, and as a reusable stimulus source in benches.

---
 rtl/bounce_generator.sv | 142 ++++++++++++++
 tb/tb_bounce_generator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_generator.sv
// Mechanical-button emulator: on a level request, drives button_out through a burst of
// LFSR-timed glitches, then settles on the requested level and pulses done.
module bounce_generator #(
    parameter int unsigned BOUNCE_COUNT  = 5,
    parameter int unsigned MIN_GAP       = 2,
    parameter int unsigned GAP_BITS      = 4,
    parameter int unsigned SETTLE_CYCLES = 2000000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic button_out,
    output logic busy,
    output logic done
);

    localparam int unsigned GAP_MAX = MIN_GAP + (2 ** GAP_BITS) - 1;
    localparam int unsigned GW      = $clog2(GAP_MAX + 1);
    localparam int unsigned EDGES   = 2 * BOUNCE_COUNT + 1;
    localparam int unsigned EW      = $clog2(EDGES + 1);
    localparam int unsigned SW      = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOUNCE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [EW-1:0] edges_q, edges_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          level_q, level_d;
    logic          button_q, button_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [GW-1:0] gap_new;

    // Next gap is always drawn from the LFSR value present at the edge that consumes it.
    assign gap_new = GW'(MIN_GAP) + GW'(lfsr_q[GAP_BITS-1:0]);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        gap_d    = gap_q;
        edges_d  = edges_q;
        settle_d = settle_q;
        level_d  = level_q;
        button_d = button_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    level_d = req_level;
                    if (req_level == button_q) begin
                        state_d = ST_DONE;
                    end else begin
                        edges_d = EW'(EDGES);
                        gap_d   = gap_new;
                        state_d = ST_BOUNCE;
                    end
                end
            end
            ST_BOUNCE: begin
                if (gap_q <= GW'(1)) begin
                    button_d = ~button_q;
                    edges_d  = edges_q - EW'(1);
                    gap_d    = gap_new;
                    if (edges_q <= EW'(1)) begin
                        // An odd edge count means the last toggle already lands on the target.
                        button_d = level_q;
                        if (SETTLE_CYCLES == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            settle_d = SW'(SETTLE_CYCLES);
                            state_d  = ST_SETTLE;
                        end
                    end
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_q <= SW'(1)) begin
                    settle_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_BOUNCE) || (state_d == ST_SETTLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            gap_q    <= '0;
            edges_q  <= '0;
            settle_q <= '0;
            level_q  <= 1'b0;
            button_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            gap_q    <= gap_d;
            edges_q  <= edges_d;
            settle_q <= settle_d;
            level_q  <= level_d;
            button_q <= button_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign req_ready  = ready_q;
    assign button_out = button_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: exact gap timing against an LFSR model, settle/done
// timing, reset abort, determinism and a downstream debounce model.
module tb_bounce_generator;

    localparam int BC      = 2;
    localparam int MG      = 3;
    localparam int GB      = 2;
    localparam int SC      = 100;
    localparam int DB_TIME = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic valid_a = 1'b0, level_a = 1'b0, valid_b = 1'b0, level_b = 1'b0;
    logic ready_a, button_a, busy_a, done_a;
    logic ready_b, button_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;
    int gap_log[0:15];
    int ref_gaps[0:15];
    logic [15:0] m_lfsr;

    int   db_cnt = 0;
    logic db_last = 1'b0;
    logic db_out = 1'b0;
    int   db_rise = 0;
    int   db_fall = 0;

    bounce_generator #(.BOUNCE_COUNT(BC), .MIN_GAP(MG), .GAP_BITS(GB), .SETTLE_CYCLES(SC)) dut_a (
        .clk(clk), .reset(reset), .req_valid(valid_a), .req_level(level_a),
        .req_ready(ready_a), .button_out(button_a), .busy(busy_a), .done(done_a)
    );

    bounce_generator #(.BOUNCE_COUNT(0), .MIN_GAP(MG), .GAP_BITS(GB), .SETTLE_CYCLES(SC)) dut_b (
        .clk(clk), .reset(reset), .req_valid(valid_b), .req_level(level_b),
        .req_ready(ready_b), .button_out(button_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, reset and stepped in lockstep with both generators.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Simple debounce downstream of generator A: follows input once stable for DB_TIME cycles.
    always @(posedge clk) begin
        if (button_a != db_last) begin
            db_last <= button_a;
            db_cnt  <= 0;
        end else if (db_cnt < DB_TIME) begin
            db_cnt <= db_cnt + 1;
        end else if (db_out != db_last) begin
            db_out <= db_last;
            if (db_last) db_rise <= db_rise + 1;
            else         db_fall <= db_fall + 1;
        end
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic btn(input bit sel);
        return sel ? button_b : button_a;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic dn(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? ready_b : ready_a;
    endfunction

    task automatic setReq(input bit sel, input logic v, input logic l);
        if (sel) begin
            valid_b = v;
            level_b = l;
        end else begin
            valid_a = v;
            level_a = l;
        end
    endtask

    // Called at a negedge. Holds reset 3 cycles, releases it, then idles 50 cycles.
    task automatic finishReset();
        int   chg;
        int   dones;
        logic prev;
        chg = 0;
        dones = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_button", button_a, 0);
        checkOutput("rst_ready", ready_a, 1);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        reset = 1'b1;
        prev = button_a;
        repeat (50) begin
            @(negedge clk);
            if (button_a != prev) chg++;
            if (done_a) dones++;
        end
        checkOutput("idle_edges", chg, 0);
        checkOutput("idle_dones", dones, 0);
        checkOutput("idle_ready", ready_a, 1);
    endtask

    // Called at a negedge. Issues a request and checks each gap against the LFSR model;
    // poke_at injects an opposite-level request while busy before edge poke_at.
    task automatic applyStimulus(input bit sel, input logic lvl, input int edges,
                                 input int poke_at, input bit full);
        int          exp_gap;
        int          n;
        int          chg;
        logic        prev;
        logic [15:0] lf_used;
        setReq(sel, 1'b1, lvl);
        exp_gap = MG + int'(m_lfsr[GB-1:0]);
        prev = btn(sel);
        @(negedge clk);
        setReq(sel, 1'b0, lvl);
        for (int k = 0; k < edges; k++) begin
            n = 0;
            if (k == poke_at) setReq(sel, 1'b1, ~lvl);
            do begin
                lf_used = m_lfsr;
                @(negedge clk);
                n++;
                if (k == poke_at) setReq(sel, 1'b0, lvl);
            end while (btn(sel) == prev && n < 20);
            checkOutput($sformatf("gap%0d", k), n, exp_gap);
            if (k == 0) checkOutput("busy_bounce", bsy(sel), 1);
            gap_log[k] = n;
            prev = btn(sel);
            exp_gap = MG + int'(lf_used[GB-1:0]);
        end
        if (full) begin
            checkOutput("final_level", btn(sel), lvl);
            n = 0;
            chg = 0;
            do begin
                @(negedge clk);
                n++;
                if (btn(sel) != lvl) chg++;
            end while (!dn(sel) && n < 300);
            checkOutput("settle_len", n, SC);
            checkOutput("settle_stable", chg, 0);
            @(negedge clk);
            checkOutput("done_width", dn(sel), 0);
            checkOutput("ready_after", rdy(sel), 1);
        end
    endtask

    initial begin
        int r0;
        int f0;

        // Reset values and quiet idle
        finishReset();

        // Press and release with exact gap timing
        applyStimulus(1'b0, 1'b1, 2 * BC + 1, -1, 1'b1);
        for (int i = 0; i < 2 * BC + 1; i++) ref_gaps[i] = gap_log[i];
        applyStimulus(1'b0, 1'b0, 2 * BC + 1, -1, 1'b1);

        // Request equal to current level: done one cycle after acceptance, never busy
        setReq(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        setReq(1'b0, 1'b0, 1'b0);
        checkOutput("nochg_done", done_a, 1);
        checkOutput("nochg_busy", busy_a, 0);
        checkOutput("nochg_button", button_a, 0);
        @(negedge clk);
        checkOutput("nochg_done_end", done_a, 0);
        checkOutput("nochg_ready", ready_a, 1);

        // Single clean edge with BOUNCE_COUNT=0
        applyStimulus(1'b1, 1'b1, 1, -1, 1'b1);

        // Reset mid-burst, then same request reproduces the gap sequence
        reset = 1'b0;
        finishReset();
        applyStimulus(1'b0, 1'b1, 2, -1, 1'b0);
        checkOutput("det_part0", gap_log[0], ref_gaps[0]);
        checkOutput("det_part1", gap_log[1], ref_gaps[1]);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_button", button_a, 0);
        checkOutput("abort_busy", busy_a, 0);
        checkOutput("abort_done", done_a, 0);
        @(negedge clk);
        finishReset();
        applyStimulus(1'b0, 1'b1, 2 * BC + 1, -1, 1'b1);
        for (int i = 0; i < 2 * BC + 1; i++)
            checkOutput($sformatf("det_full%0d", i), gap_log[i], ref_gaps[i]);
        applyStimulus(1'b0, 1'b0, 2 * BC + 1, -1, 1'b1);

        // Ignored request while busy, plus debounce integration
        repeat (30) @(negedge clk);
        r0 = db_rise;
        f0 = db_fall;
        applyStimulus(1'b0, 1'b1, 2 * BC + 1, 1, 1'b1);
        applyStimulus(1'b0, 1'b0, 2 * BC + 1, -1, 1'b1);
        repeat (30) @(negedge clk);
        checkOutput("db_rises", db_rise - r0, 1);
        checkOutput("db_falls", db_fall - f0, 1);
        checkOutput("db_level", db_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
